// File: rtl/bip_run_sequencer.sv
// Run controller for the BIP accumulator CPU.
// Clears the CPU on start, gates decoder write enables in free-run or
// single-step mode until HLT, counts executed instructions (saturating),
// then sends ACC, PC and the count as six bytes over a start/busy UART
// handshake.
module bip_run_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 11,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [PC_W-1:0]   pc,
  input  logic              tx_busy,
  output logic              cpu_en,
  output logic              cpu_clr,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_REP_SEND,
    S_REP_GUARD,
    S_REP_WAIT,
    S_DONE
  } state_t;

  localparam logic [4:0] OP_HLT = 5'b00000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      rep_acc_q, rep_acc_d;
  logic [15:0]      rep_pc_q, rep_pc_d;
  logic [15:0]      rep_cnt_q, rep_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       byte_sel;
  logic             cpu_clr_q, tx_start_q, busy_q, halted_q;
  logic             exec, run_ok, hlt_seen;

  // An instruction slot is taken every RUN cycle in free-run, only on step pulses otherwise.
  always_comb begin
    exec     = (state_q == S_RUN) && (!step_mode || step);
    run_ok   = exec && (opcode != OP_HLT);
    hlt_seen = exec && (opcode == OP_HLT);
    cpu_en   = run_ok;
  end

  // Next-state, counter, report snapshot and byte-index logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rep_acc_d = rep_acc_q;
    rep_pc_d  = rep_pc_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (run_ok && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (hlt_seen) begin
          state_d   = S_REP_SEND;
          idx_d     = '0;
          rep_acc_d = 16'(acc);
          rep_pc_d  = 16'(pc);
          rep_cnt_d = 16'(cnt_q);
        end
      end
      S_REP_SEND:  state_d = S_REP_GUARD;
      S_REP_GUARD: state_d = S_REP_WAIT;
      S_REP_WAIT: begin
        if (!tx_busy) begin
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd5) ? S_DONE : S_REP_SEND;
        end
      end
      S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state
  // they describe; the byte is picked from the next-cycle snapshot/index so the
  // first byte is correct on the same edge that takes the snapshot.
  always_comb begin
    byte_sel = '0;
    case (idx_d)
      3'd0: byte_sel = rep_acc_d[15:8];
      3'd1: byte_sel = rep_acc_d[7:0];
      3'd2: byte_sel = rep_pc_d[15:8];
      3'd3: byte_sel = rep_pc_d[7:0];
      3'd4: byte_sel = rep_cnt_d[15:8];
      3'd5: byte_sel = rep_cnt_d[7:0];
      default: byte_sel = '0;
    endcase
    tx_data_d = (state_d == S_REP_SEND) ? byte_sel : tx_data_q;
  end

  // State, counter and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      rep_acc_q <= '0;
      rep_pc_q  <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rep_acc_q <= rep_acc_d;
      rep_pc_q  <= rep_pc_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_clr_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      cpu_clr_q  <= (state_d == S_CLEAR);
      tx_start_q <= (state_d == S_REP_SEND);
      tx_data_q  <= tx_data_d;
      busy_q     <= (state_d != S_IDLE);
      halted_q   <= (state_d == S_DONE);
    end
  end

  assign cpu_clr  = cpu_clr_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_bip_run_sequencer.sv
// Directed bench for bip_run_sequencer with a tiny CPU and UART model.
module tb_bip_run_sequencer;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LDI  = 5'd5;
  localparam logic [4:0] OP_ADDI = 5'd6;
  localparam logic [4:0] OP_NOP  = 5'd31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [4:0]  opcode;
  logic [15:0] acc_m = '0;
  logic [10:0] pc_m = '0;
  logic        tx_busy = 1'b0;
  logic        cpu_en, cpu_clr, tx_start, busy, halted;
  logic [7:0]  tx_data;

  logic [4:0]  prog_op [16];
  logic [15:0] prog_imm [16];
  logic        ovr_en = 1'b0;
  logic [4:0]  ovr_op = OP_NOP;

  int          errors = 0;
  int          checks = 0;
  int          busy_len = 2;
  int          rem = 0;
  int          cycle = 0;
  int          en_cnt = 0;
  int          clr_cnt = 0;
  int          en_nostep = 0;
  int          stab_err = 0;
  logic [7:0]  last_b = '0;
  bit          have_b = 1'b0;
  logic [7:0]  txq [$];
  int          tcyc [$];

  always #5 clk = ~clk;

  bip_run_sequencer #(.DATA_W(16), .PC_W(11), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .opcode(opcode), .acc(acc_m), .pc(pc_m), .tx_busy(tx_busy),
    .cpu_en(cpu_en), .cpu_clr(cpu_clr), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .halted(halted)
  );

  assign opcode = ovr_en ? ovr_op : prog_op[pc_m[3:0]];

  // Accumulator CPU: clear, then execute one instruction per enabled cycle.
  always @(posedge clk) begin
    if (cpu_clr) begin
      acc_m <= '0;
      pc_m  <= '0;
    end else if (cpu_en) begin
      case (opcode)
        OP_LDI:  acc_m <= prog_imm[pc_m[3:0]];
        OP_ADDI: acc_m <= acc_m + prog_imm[pc_m[3:0]];
        default: ;
      endcase
      pc_m <= pc_m + 11'd1;
    end
  end

  // Activity counters sampled on the active edge.
  always @(posedge clk) begin
    cycle = cycle + 1;
    if (cpu_en) en_cnt = en_cnt + 1;
    if (cpu_clr) clr_cnt = clr_cnt + 1;
    if (cpu_en && step_mode && !step) en_nostep = en_nostep + 1;
  end

  // UART: capture bytes, hold busy busy_len+1 edges, watch tx_data stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_busy = 1'b0;
      rem = 0;
      have_b = 1'b0;
    end else if (tx_start) begin
      txq.push_back(tx_data);
      tcyc.push_back(cycle);
      last_b = tx_data;
      have_b = 1'b1;
      tx_busy = 1'b1;
      rem = busy_len;
    end else begin
      if (have_b && tx_data !== last_b) stab_err = stab_err + 1;
      if (rem > 0) rem = rem - 1;
      else tx_busy = 1'b0;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_main();
    for (int i = 0; i < 16; i++) begin
      prog_op[i] = OP_HLT;
      prog_imm[i] = '0;
    end
    prog_op[0] = OP_LDI;  prog_imm[0] = 16'd5;
    prog_op[1] = OP_ADDI; prog_imm[1] = 16'd3;
    prog_op[2] = OP_STO;  prog_imm[2] = 16'd2;
    prog_op[3] = OP_HLT;
  endtask

  task automatic wait_halt(input int bound, output bit to);
    to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (halted === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (cpu_en !== 1'b0)   begin errors++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    checks++; if (cpu_clr !== 1'b0)  begin errors++; $display("FAIL reset_cpu_clr: got %b want 0", cpu_clr); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (halted !== 1'b0)   begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_free_run();
    logic [7:0] exp_b [6] = '{8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h03};
    int qb = txq.size();
    int eb = en_cnt;
    int cb = clr_cnt;
    bit to;
    load_main();
    step_mode = 1'b0;
    pulse_start();
    checks++; if (cpu_clr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL free_clear_state: got clr=%b busy=%b want 1 1", cpu_clr, busy); end
    wait_halt(500, to);
    checks++; if (to) begin errors++; $display("FAIL free_timeout: got no halt want halted"); end
    checks++; if (clr_cnt - cb != 1) begin errors++; $display("FAIL free_clr_cycles: got %0d want 1", clr_cnt - cb); end
    checks++; if (en_cnt - eb != 3) begin errors++; $display("FAIL free_en_cycles: got %0d want 3", en_cnt - eb); end
    checks++; if (txq.size() - qb != 6) begin errors++; $display("FAIL free_byte_count: got %0d want 6", txq.size() - qb); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL free_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
    checks++; if (halted !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL free_done: got halted=%b busy=%b want 1 1", halted, busy); end
  endtask

  task automatic test_single_step();
    logic [7:0] exp_b [6] = '{8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h03};
    int qb = txq.size();
    int eb = en_cnt;
    int nb = en_nostep;
    bit to;
    load_main();
    step_mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      repeat (10) cyc();
      checks++; if (txq.size() != qb) begin errors++; $display("FAIL step_early_report_%0d: got %0d bytes want 0", k, txq.size() - qb); end
      step = 1'b1;
      cyc();
      step = 1'b0;
    end
    wait_halt(500, to);
    step_mode = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL step_timeout: got no halt want halted"); end
    checks++; if (en_cnt - eb != 3) begin errors++; $display("FAIL step_en_cycles: got %0d want 3", en_cnt - eb); end
    checks++; if (en_nostep - nb != 0) begin errors++; $display("FAIL step_en_without_step: got %0d want 0", en_nostep - nb); end
    checks++; if (txq.size() - qb != 6) begin errors++; $display("FAIL step_byte_count: got %0d want 6", txq.size() - qb); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL step_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
  endtask

  task automatic test_busy_hold();
    logic [7:0] exp_b [6] = '{8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h03};
    int qb = txq.size();
    int sb = stab_err;
    bit to;
    load_main();
    busy_len = 20;
    pulse_start();
    wait_halt(1000, to);
    busy_len = 2;
    checks++; if (to) begin errors++; $display("FAIL busy_timeout: got no halt want halted"); end
    checks++; if (txq.size() - qb != 6) begin errors++; $display("FAIL busy_pulse_count: got %0d want 6", txq.size() - qb); end
    for (int i = 1; i < 6; i++) begin
      int gap;
      gap = (qb + i < tcyc.size()) ? tcyc[qb + i] - tcyc[qb + i - 1] : 0;
      checks++; if (gap < 22) begin errors++; $display("FAIL busy_gap%0d: got %0d want >=22", i, gap); end
    end
    checks++; if (stab_err - sb != 0) begin errors++; $display("FAIL busy_tx_data_stable: got %0d changes want 0", stab_err - sb); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL busy_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
  endtask

  task automatic test_hlt_first_rerun();
    logic [7:0] exp_b [6] = '{8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h03};
    int qb = txq.size();
    int eb = en_cnt;
    bit to;
    for (int i = 0; i < 16; i++) prog_op[i] = OP_HLT;
    pulse_start();
    wait_halt(500, to);
    checks++; if (to) begin errors++; $display("FAIL hltfirst_timeout: got no halt want halted"); end
    checks++; if (en_cnt != eb) begin errors++; $display("FAIL hltfirst_en_cycles: got %0d want 0", en_cnt - eb); end
    checks++; if (txq.size() - qb != 6) begin errors++; $display("FAIL hltfirst_byte_count: got %0d want 6", txq.size() - qb); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== 8'h00) begin errors++; $display("FAIL hltfirst_byte%0d: got %h want 00", i, g); end
    end
    load_main();
    qb = txq.size();
    pulse_start();
    checks++; if (halted !== 1'b0 || cpu_clr !== 1'b1) begin errors++; $display("FAIL rerun_leave_done: got halted=%b clr=%b want 0 1", halted, cpu_clr); end
    wait_halt(500, to);
    checks++; if (to) begin errors++; $display("FAIL rerun_timeout: got no halt want halted"); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL rerun_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid_report();
    logic [7:0] exp_b [6] = '{8'h00, 8'h08, 8'h00, 8'h03, 8'h00, 8'h03};
    int qb = txq.size();
    bit got4 = 1'b0;
    bit to;
    load_main();
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (txq.size() - qb >= 4) begin
        got4 = 1'b1;
        break;
      end
    end
    checks++; if (!got4) begin errors++; $display("FAIL rstmid_reach_byte3: got %0d bytes want 4", txq.size() - qb); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_start !== 1'b0 || cpu_en !== 1'b0 || cpu_clr !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got start=%b en=%b clr=%b halted=%b want 0 0 0 0", tx_start, cpu_en, cpu_clr, halted);
    end
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b want 0", busy); end
    qb = txq.size();
    pulse_start();
    wait_halt(500, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_timeout: got no halt want halted"); end
    checks++; if (txq.size() - qb != 6) begin errors++; $display("FAIL rstmid_byte_count: got %0d want 6", txq.size() - qb); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
  endtask

  task automatic test_saturate();
    // 70000 executed instructions: PC wraps to 70000 mod 2048 = 0x170, count saturates.
    logic [7:0] exp_b [6] = '{8'h00, 8'h00, 8'h01, 8'h70, 8'hFF, 8'hFF};
    int qb = txq.size();
    int eb = en_cnt;
    int cb;
    bit reached = 1'b0;
    bit to;
    ovr_op = OP_NOP;
    ovr_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 71000; i++) begin
      if (en_cnt - eb >= 70000) begin
        reached = 1'b1;
        break;
      end
      cyc();
    end
    ovr_op = OP_HLT;
    checks++; if (!reached) begin errors++; $display("FAIL sat_run_length: got %0d want 70000", en_cnt - eb); end
    cb = clr_cnt;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (txq.size() - qb >= 2) break;
    end
    pulse_start();
    step = 1'b1;
    cyc();
    step = 1'b0;
    pulse_start();
    wait_halt(500, to);
    ovr_en = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL sat_timeout: got no halt want halted"); end
    checks++; if (en_cnt - eb != 70000) begin errors++; $display("FAIL sat_en_cycles: got %0d want 70000", en_cnt - eb); end
    checks++; if (clr_cnt != cb) begin errors++; $display("FAIL sat_start_in_report: got %0d clears want 0", clr_cnt - cb); end
    checks++; if (txq.size() - qb != 6) begin errors++; $display("FAIL sat_byte_count: got %0d want 6", txq.size() - qb); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (qb + i < txq.size()) ? txq[qb + i] : 8'hxx;
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL sat_byte%0d: got %h want %h", i, g, exp_b[i]); end
    end
    repeat (5) cyc();
    checks++; if (txq.size() - qb != 6 || halted !== 1'b1) begin errors++; $display("FAIL sat_stays_done: got bytes=%0d halted=%b want 6 1", txq.size() - qb, halted); end
  endtask

  initial begin
    load_main();
    test_reset();
    test_free_run();
    test_single_step();
    test_busy_hold();
    test_hlt_first_rerun();
    test_reset_mid_report();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
